// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM:
// state codes, opcode/funct values, ALU ops and mux selects.
package mips_ctrl_pkg;

  typedef enum logic [7:0] {
    ST_RESET      = 8'd0,
    ST_FETCH      = 8'd1,
    ST_FETCH_WAIT = 8'd2,
    ST_DECODE     = 8'd3,
    ST_MEM_ADDR   = 8'd4,
    ST_MEM_READ   = 8'd5,
    ST_MEM_WAIT   = 8'd6,
    ST_LW_WB      = 8'd7,
    ST_MEM_WRITE  = 8'd8,
    ST_R_EXEC     = 8'd9,
    ST_R_WB       = 8'd10,
    ST_BRANCH     = 8'd11,
    ST_JUMP       = 8'd12,
    ST_ADDI_EXEC  = 8'd13,
    ST_I_WB       = 8'd14,
    ST_JR         = 8'd15,
    ST_HALT       = 8'd16,
    ST_EXC_EPC    = 8'd17,
    ST_EXC_JUMP   = 8'd18
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_XOR   = 6'h26;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_EXC = 2'b11;

  function automatic logic is_arith(logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB);
  endfunction

endpackage

// File: rtl/mips_control_unit.sv
// Multicycle MIPS main control FSM (Moore, branch PC_load aside).
// Define CTRL_EXCEPTION_EN for EPC/vector exception handling.
module mips_control_unit
  import mips_ctrl_pkg::*;
(
  input  logic       Clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Overflow,
  output logic       PC_load,
  output logic       IorD,
  output logic       wr,
  output logic       IRWrite,
  output logic       MDR_load,
  output logic       AB_load,
  output logic       AluOut_load,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUCtrl,
  output logic [1:0] PCSource,
  output logic       EPC_load,
  output logic [7:0] Estado
);

`ifdef CTRL_EXCEPTION_EN
  localparam state_t UNK_NEXT = ST_EXC_EPC;
`else
  localparam state_t UNK_NEXT = ST_FETCH;
`endif

  state_t state, next;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state <= ST_RESET;
    else       state <= next;
  end

  assign Estado = state;

  always_comb begin
    next        = state;
    PC_load     = 1'b0;
    IorD        = 1'b0;
    wr          = 1'b0;
    IRWrite     = 1'b0;
    MDR_load    = 1'b0;
    AB_load     = 1'b0;
    AluOut_load = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUCtrl     = ALU_PASS;
    PCSource    = PCSRC_ALU;
    EPC_load    = 1'b0;
    unique case (state)
      ST_RESET: next = ST_FETCH;
      ST_FETCH: next = ST_FETCH_WAIT;
      ST_FETCH_WAIT: begin
        IRWrite = 1'b1;
        ALUSrcB = SRCB_4;
        ALUCtrl = ALU_ADD;
        PC_load = 1'b1;
        next    = ST_DECODE;
      end
      ST_DECODE: begin
        AB_load     = 1'b1;
        ALUSrcB     = SRCB_IMM4;
        ALUCtrl     = ALU_ADD;
        AluOut_load = 1'b1;
        unique case (Opcode)
          OP_R: begin
            unique case (Funct)
              FN_ADD, FN_SUB,
              FN_AND, FN_XOR: next = ST_R_EXEC;
              FN_JR:          next = ST_JR;
              FN_BREAK:       next = ST_HALT;
              default:        next = UNK_NEXT;
            endcase
          end
          OP_LW, OP_SW:    next = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:  next = ST_BRANCH;
          OP_J:            next = ST_JUMP;
          OP_ADDI:         next = ST_ADDI_EXEC;
          default:         next = UNK_NEXT;
        endcase
      end
      ST_MEM_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALUCtrl     = ALU_ADD;
        AluOut_load = 1'b1;
        next = (Opcode == OP_LW) ? ST_MEM_READ
                                 : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        IorD = 1'b1;
        next = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        MDR_load = 1'b1;
        next     = ST_LW_WB;
      end
      ST_LW_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        next     = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        IorD = 1'b1;
        wr   = 1'b1;
        next = ST_FETCH;
      end
      ST_R_EXEC: begin
        ALUSrcA     = 1'b1;
        AluOut_load = 1'b1;
        unique case (Funct)
          FN_SUB:  ALUCtrl = ALU_SUB;
          FN_AND:  ALUCtrl = ALU_AND;
          FN_XOR:  ALUCtrl = ALU_XOR;
          default: ALUCtrl = ALU_ADD;
        endcase
        next = ST_R_WB;
`ifdef CTRL_EXCEPTION_EN
        if (Overflow && is_arith(Funct))
          next = ST_EXC_EPC;
`endif
      end
      ST_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        next     = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUCtrl  = ALU_SUB;
        PCSource = PCSRC_OUT;
        PC_load  = (Opcode == OP_BNE) ? !Zero : Zero;
        next     = ST_FETCH;
      end
      ST_JUMP: begin
        PCSource = PCSRC_JMP;
        PC_load  = 1'b1;
        next     = ST_FETCH;
      end
      ST_ADDI_EXEC: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALUCtrl     = ALU_ADD;
        AluOut_load = 1'b1;
        next        = ST_I_WB;
`ifdef CTRL_EXCEPTION_EN
        if (Overflow) next = ST_EXC_EPC;
`endif
      end
      ST_I_WB: begin
        RegWrite = 1'b1;
        next     = ST_FETCH;
      end
      ST_JR: begin
        ALUSrcA = 1'b1;
        PC_load = 1'b1;
        next    = ST_FETCH;
      end
      ST_HALT: next = ST_HALT;
`ifdef CTRL_EXCEPTION_EN
      // EPC holds the faulting instruction: PC was already advanced by 4
      ST_EXC_EPC: begin
        ALUSrcB  = SRCB_4;
        ALUCtrl  = ALU_SUB;
        EPC_load = 1'b1;
        next     = ST_EXC_JUMP;
      end
      ST_EXC_JUMP: begin
        PCSource = PCSRC_EXC;
        PC_load  = 1'b1;
        next     = ST_FETCH;
      end
`endif
      default: next = ST_FETCH;
    endcase
  end

endmodule
